// File: rtl/button_event_scheduler_if.sv
// Bundle of button inputs, event handshake and status flags shared by the
// scheduler and whoever drives the buttons / consumes the events.
interface button_event_scheduler_if;
    logic [2:0] b_level;
    logic       evt_ready;
    logic       ovf_clr;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic [2:0] evt_count;
    logic       overflow;

    modport master (
        output b_level, evt_ready, ovf_clr,
        input  evt_valid, evt_code, evt_count, overflow
    );

    modport slave (
        input  b_level, evt_ready, ovf_clr,
        output evt_valid, evt_code, evt_count, overflow
    );
endinterface

// File: rtl/button_event_scheduler.sv
// Turns three debounced button levels into short/long press events, holds one
// pending event per button and queues them in priority order into a 4-deep FIFO.
module button_event_scheduler #(
    parameter logic [15:0] LONG_CYCLES = 16'd50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    button_event_scheduler_if.slave     bus
);

    logic [15:0] hc_r [3];
    logic [2:0]  long_evt_s;
    logic [2:0]  short_evt_s;
    logic [2:0]  gen_s;
    logic [2:0]  drop_s;
    logic [2:0]  pend_v_r;
    logic [2:0]  pend_l_r;
    logic [2:0]  grant_s;
    logic [2:0]  push_code_s;
    logic        push_s;
    logic        pop_s;
    logic        full_s;
    logic [2:0]  count_next_s;
    logic [2:0]  fifo_mem_r [4];
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [2:0]  count_r;
    logic        evt_valid_r;
    logic        overflow_r;

    // Press classification from the current hold count and the sampled level.
    always_comb begin
        long_evt_s  = 3'b000;
        short_evt_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            long_evt_s[i]  = bus.b_level[i] && (hc_r[i] == (LONG_CYCLES - 16'd1));
            short_evt_s[i] = !bus.b_level[i] && (hc_r[i] != 16'd0) && (hc_r[i] < LONG_CYCLES);
        end
        gen_s = long_evt_s | short_evt_s;
    end

    // Fixed-priority grant of one pending slot; a full FIFO accepts only if it pops.
    always_comb begin
        pop_s       = evt_valid_r && bus.evt_ready;
        full_s      = (count_r == 3'd4);
        grant_s     = 3'b000;
        push_code_s = 3'b000;
        if (!full_s || pop_s) begin
            if (pend_v_r[0]) begin
                grant_s     = 3'b001;
                push_code_s = {pend_l_r[0], 2'd0};
            end else if (pend_v_r[1]) begin
                grant_s     = 3'b010;
                push_code_s = {pend_l_r[1], 2'd1};
            end else if (pend_v_r[2]) begin
                grant_s     = 3'b100;
                push_code_s = {pend_l_r[2], 2'd2};
            end else begin
                grant_s     = 3'b000;
                push_code_s = 3'b000;
            end
        end else begin
            grant_s     = 3'b000;
            push_code_s = 3'b000;
        end
        push_s       = |grant_s;
        // A slot being granted this edge can take a new event without loss.
        drop_s       = gen_s & pend_v_r & ~grant_s;
        count_next_s = count_r + {2'b00, push_s} - {2'b00, pop_s};
    end

    // Per-button hold counters, saturating so a held button yields one long event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                hc_r[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!bus.b_level[i]) begin
                    hc_r[i] <= 16'd0;
                end else if (hc_r[i] != LONG_CYCLES) begin
                    hc_r[i] <= hc_r[i] + 16'd1;
                end else begin
                    hc_r[i] <= hc_r[i];
                end
            end
        end
    end

    // Pending slots: refill on a new event, clear when granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_r <= 3'b000;
            pend_l_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (gen_s[i] && (!pend_v_r[i] || grant_s[i])) begin
                    pend_v_r[i] <= 1'b1;
                    pend_l_r[i] <= long_evt_s[i];
                end else if (grant_s[i]) begin
                    pend_v_r[i] <= 1'b0;
                end else begin
                    pend_v_r[i] <= pend_v_r[i];
                end
            end
        end
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 3'b000;
            end
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            count_r     <= 3'd0;
            evt_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_code_s;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r     <= count_next_s;
            evt_valid_r <= (count_next_s != 3'd0);
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (|drop_s) begin
            overflow_r <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign bus.evt_valid = evt_valid_r;
    assign bus.evt_code  = fifo_mem_r[rd_ptr_r];
    assign bus.evt_count = count_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with LONG_CYCLES = 8; expected event
// codes are queued when a press is driven and checked as the consumer pops them.
module tb_button_event_scheduler;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [2:0] sb[$];

    button_event_scheduler_if bus();

    button_event_scheduler #(.LONG_CYCLES(16'd8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Consumer side: every accepted event must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pop: observed code=%0h expected no event", bus.evt_code);
            end
            if (sb.size() != 0) begin
                chk("pop_code", {13'd0, bus.evt_code}, {13'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.b_level = 3'b000;
        bus.evt_ready = 1'b0;
        bus.ovf_clr = 1'b0;

        #3;
        chk("rst_valid", {15'd0, bus.evt_valid}, 16'd0);
        chk("rst_count", {13'd0, bus.evt_count}, 16'd0);
        chk("rst_ovf", {15'd0, bus.overflow}, 16'd0);
        chk("rst_code", {13'd0, bus.evt_code}, 16'd0);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // Short press of button 0
        bus.evt_ready = 1'b1;
        bus.b_level = 3'b001;
        tick(3);
        sb.push_back(3'b000);
        bus.b_level = 3'b000;
        tick(1);
        chk("short_lat0", {15'd0, bus.evt_valid}, 16'd0);
        tick(1);
        chk("short_valid", {15'd0, bus.evt_valid}, 16'd1);
        chk("short_code", {13'd0, bus.evt_code}, 16'd0);
        tick(1);
        chk("short_gone", {15'd0, bus.evt_valid}, 16'd0);
        chk("short_cnt0", {13'd0, bus.evt_count}, 16'd0);

        // Long press of button 1, held 20 samples
        bus.b_level = 3'b010;
        sb.push_back(3'b101);
        tick(7);
        chk("long_early", {15'd0, bus.evt_valid}, 16'd0);
        tick(1);
        chk("long_lat", {15'd0, bus.evt_valid}, 16'd0);
        tick(1);
        chk("long_valid", {15'd0, bus.evt_valid}, 16'd1);
        chk("long_code", {13'd0, bus.evt_code}, 16'd5);
        tick(11);
        bus.b_level = 3'b000;
        tick(4);
        chk("long_no_rel", {15'd0, bus.evt_valid}, 16'd0);
        chk("long_cnt0", {13'd0, bus.evt_count}, 16'd0);

        // Simultaneous release of all three buttons
        bus.evt_ready = 1'b0;
        bus.b_level = 3'b111;
        tick(3);
        bus.b_level = 3'b000;
        sb.push_back(3'b000);
        sb.push_back(3'b001);
        sb.push_back(3'b010);
        tick(1);
        chk("sim_cnt0", {13'd0, bus.evt_count}, 16'd0);
        tick(1);
        chk("sim_cnt1", {13'd0, bus.evt_count}, 16'd1);
        tick(1);
        chk("sim_cnt2", {13'd0, bus.evt_count}, 16'd2);
        tick(1);
        chk("sim_cnt3", {13'd0, bus.evt_count}, 16'd3);
        bus.evt_ready = 1'b1;
        tick(3);
        chk("sim_drained", {13'd0, bus.evt_count}, 16'd0);

        // Six short presses of button 2 into a stalled consumer
        bus.evt_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.b_level = 3'b100;
            tick(2);
            bus.b_level = 3'b000;
            if (k < 5) sb.push_back(3'b010);
            tick(1);
        end
        chk("ovf_set", {15'd0, bus.overflow}, 16'd1);
        chk("full_cnt", {13'd0, bus.evt_count}, 16'd4);
        tick(2);
        chk("full_sat", {13'd0, bus.evt_count}, 16'd4);
        bus.ovf_clr = 1'b1;
        tick(1);
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", {15'd0, bus.overflow}, 16'd0);

        // Pop and pending grant on the same edge at full
        bus.evt_ready = 1'b1;
        tick(1);
        bus.evt_ready = 1'b0;
        chk("popfull_cnt", {13'd0, bus.evt_count}, 16'd4);
        tick(1);
        chk("popfull_hold", {13'd0, bus.evt_count}, 16'd4);
        bus.evt_ready = 1'b1;
        tick(6);
        chk("drain_cnt", {13'd0, bus.evt_count}, 16'd0);
        chk("drain_valid", {15'd0, bus.evt_valid}, 16'd0);
        chk("drain_sb", sb.size(), 16'd0);

        // Reset while events are queued and button 0 is held
        bus.evt_ready = 1'b0;
        bus.b_level = 3'b111;
        tick(3);
        bus.b_level = 3'b000;
        tick(4);
        chk("pre_rst_cnt", {13'd0, bus.evt_count}, 16'd3);
        bus.b_level = 3'b001;
        tick(5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {15'd0, bus.evt_valid}, 16'd0);
        chk("mid_rst_cnt", {13'd0, bus.evt_count}, 16'd0);
        chk("mid_rst_ovf", {15'd0, bus.overflow}, 16'd0);
        #2;
        rst_n = 1'b1;
        sb.delete();
        tick(3);
        chk("post_rst_cnt", {13'd0, bus.evt_count}, 16'd0);
        sb.push_back(3'b000);
        bus.b_level = 3'b000;
        bus.evt_ready = 1'b1;
        tick(1);
        chk("post_rst_lat", {15'd0, bus.evt_valid}, 16'd0);
        tick(1);
        chk("post_rst_valid", {15'd0, bus.evt_valid}, 16'd1);
        chk("post_rst_code", {13'd0, bus.evt_code}, 16'd0);
        tick(3);
        chk("post_rst_cnt0", {13'd0, bus.evt_count}, 16'd0);
        chk("final_sb", sb.size(), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
